// File: rtl/serial_frame_receiver.sv
// Deserialises one readout frame: a timestamp word followed by encoded samples.
// Samples are queued in a small valid/ready FIFO; truncation and overflow are flagged.
module serial_frame_receiver #(
  parameter int TIME_BITS   = 32,
  parameter int SAMPLE_BITS = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_SAMPLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   frame_active,
  input  logic                   bit_valid,
  input  logic                   serial_in,
  output logic [TIME_BITS-1:0]   time_stamp,
  output logic                   time_valid,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [8:0]             sample_count,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(TIME_BITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] TIME_LAST = CNT_W'(TIME_BITS - 1);
  localparam logic [CNT_W-1:0] SMP_LAST  = CNT_W'(SAMPLE_BITS - 1);
  localparam logic [8:0]       SMP_MAX   = 9'(MAX_SAMPLES);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TIME,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [TIME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TIME_BITS-1:0]   time_stamp_q, time_stamp_d;
  logic                   time_valid_q, time_valid_d;
  logic [8:0]             smp_cnt_q, smp_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_error_q, frame_error_d;
  logic                   active_q, active_d;
  logic                   overflow_q, overflow_d;

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [SAMPLE_BITS-1:0] mem_d [FIFO_DEPTH];

  logic                   push;
  logic [SAMPLE_BITS-1:0] push_data;
  logic [TIME_BITS-1:0]   shifted;
  logic                   fall;
  logic                   take_bit;
  logic                   do_push;
  logic                   do_pop;
  logic                   full;

  assign shifted  = {shift_q[TIME_BITS-2:0], serial_in};
  assign fall     = active_q && !frame_active;
  assign take_bit = bit_valid && frame_active;
  assign active_d = frame_active;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    time_stamp_d  = time_stamp_q;
    time_valid_d  = 1'b0;
    smp_cnt_d     = smp_cnt_q;
    frame_done_d  = 1'b0;
    frame_error_d = frame_error_q;
    push          = 1'b0;
    push_data     = shifted[SAMPLE_BITS-1:0];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (frame_start) begin
          state_d       = S_TIME;
          shift_d       = '0;
          bit_cnt_d     = '0;
          smp_cnt_d     = '0;
          frame_error_d = 1'b0;
        end
      end
      S_TIME, S_SAMPLE: begin
        if (frame_start) begin
          // Restart aborts the frame in flight
          state_d       = S_TIME;
          shift_d       = '0;
          bit_cnt_d     = '0;
          smp_cnt_d     = '0;
          frame_error_d = 1'b1;
        end else if (fall) begin
          state_d = S_DONE;
          if (state_q == S_TIME || bit_cnt_q != '0) begin
            frame_error_d = 1'b1;
          end else begin
            frame_done_d = 1'b1;
          end
        end else if (take_bit) begin
          shift_d = shifted;
          if (state_q == S_TIME) begin
            if (bit_cnt_q == TIME_LAST) begin
              time_stamp_d = shifted;
              time_valid_d = 1'b1;
              state_d      = S_SAMPLE;
              bit_cnt_d    = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (bit_cnt_q == SMP_LAST) begin
            bit_cnt_d = '0;
            if (smp_cnt_q == SMP_MAX) begin
              frame_error_d = 1'b1;
            end else begin
              push      = 1'b1;
              smp_cnt_d = smp_cnt_q + 9'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    full       = (occ_q == OCC_FULL);
    do_pop     = sample_ready && (occ_q != '0);
    do_push    = push && (!full || do_pop);
    overflow_d = overflow_q || (push && !do_push);
    wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
    occ_d      = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    mem_d      = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      time_stamp_q  <= '0;
      time_valid_q  <= 1'b0;
      smp_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      active_q      <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      mem_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      time_stamp_q  <= time_stamp_d;
      time_valid_q  <= time_valid_d;
      smp_cnt_q     <= smp_cnt_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      active_q      <= active_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      mem_q         <= mem_d;
    end
  end

  assign time_stamp   = time_stamp_q;
  assign time_valid   = time_valid_q;
  assign sample_valid = (occ_q != '0);
  assign sample_data  = sample_valid ? mem_q[rd_ptr_q] : '0;
  assign sample_count = smp_cnt_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomised bench for serial_frame_receiver against a queue-based
// model of the FIFO and per-frame expectations derived from the frame layout.
module tb_serial_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_active = 1'b0;
  logic        bit_valid = 1'b0;
  logic        serial_in = 1'b0;
  logic        sample_ready = 1'b0;
  logic [31:0] time_stamp;
  logic        time_valid;
  logic [2:0]  sample_data;
  logic        sample_valid;
  logic [8:0]  sample_count;
  logic        frame_done;
  logic        frame_error;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_frame_receiver dut (
    .clk          (clk),
    .reset        (rst_n),
    .frame_start  (frame_start),
    .frame_active (frame_active),
    .bit_valid    (bit_valid),
    .serial_in    (serial_in),
    .time_stamp   (time_stamp),
    .time_valid   (time_valid),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_count (sample_count),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [2:0]  m_q[$];
  logic [31:0] m_ts = '0;
  logic        m_tv = 1'b0;
  logic        m_ovf = 1'b0;
  bit          armed = 1'b0;
  int          done_cnt = 0;
  int          done_base = 0;
  bit          ev_ts = 1'b0;
  logic [31:0] ev_ts_val = '0;
  bit          ev_push = 1'b0;
  logic [2:0]  ev_push_val = '0;
  int          ready_mode = 1;
  logic [2:0]  smp[$];

  // Model state is what the DUT should show after the previous edge
  always @(negedge clk) begin
    if (armed) begin
      chk("time_stamp", time_stamp, m_ts);
      chk("time_valid", time_valid, m_tv);
      chk("sample_valid", sample_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("sample_data", sample_data, m_q[0]);
      chk("overflow", overflow, m_ovf);
    end
    if (frame_done) done_cnt++;
    if (!rst_n) begin
      m_q.delete();
      m_ts = '0;
      m_tv = 1'b0;
      m_ovf = 1'b0;
      armed = 1'b1;
    end else begin
      m_tv = ev_ts;
      if (ev_ts) m_ts = ev_ts_val;
      if (m_q.size() != 0 && sample_ready) m_q.delete(0);
      if (ev_push) begin
        if (m_q.size() < 8) m_q.push_back(ev_push_val);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sample_ready = 1'b0;
      1:       sample_ready = 1'b1;
      default: sample_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    frame_active = 1'b0;
    frame_start = 1'b0;
    repeat (n) begin
      bit_valid = 1'($urandom_range(0, 1));
      serial_in = 1'($urandom_range(0, 1));
      step();
    end
    bit_valid = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    frame_active = 1'b1;
    bit_valid = 1'b0;
    step();
    frame_start = 1'b0;
    done_base = done_cnt;
  endtask

  // gap: 0 none, 1 bit on every 3rd cycle, 2 random
  task automatic send_bits(input logic [31:0] ts, input int nbits,
                           input int gap);
    int g, k, j;
    logic [2:0] s;
    for (int i = 0; i < nbits; i++) begin
      g = (gap == 1) ? 2 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (g) begin
        bit_valid = 1'b0;
        serial_in = 1'($urandom_range(0, 1));
        step();
      end
      k = 0;
      j = 0;
      s = '0;
      if (i < 32) begin
        serial_in = ts[31-i];
      end else begin
        k = (i - 32) / 3;
        j = (i - 32) % 3;
        s = smp[k];
        serial_in = s[2-j];
      end
      bit_valid = 1'b1;
      ev_ts = (i == 31);
      ev_ts_val = ts;
      ev_push = (i >= 32) && (j == 2) && (k < 256);
      ev_push_val = s;
      step();
      ev_ts = 1'b0;
      ev_push = 1'b0;
      bit_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [31:0] ts, input int nbits,
                           input int gap, input bit prior_err);
    int nc;
    bit partial;
    start_frame();
    send_bits(ts, nbits, gap);
    frame_active = 1'b0;
    bit_valid = 1'($urandom_range(0, 1));
    serial_in = 1'($urandom_range(0, 1));
    step();
    bit_valid = 1'b0;
    step();
    partial = (nbits < 32) || (((nbits - 32) % 3) != 0);
    nc = (nbits < 32) ? 0 : (nbits - 32) / 3;
    chk("sample_count", sample_count, (nc > 256) ? 256 : nc);
    chk("frame_error", frame_error, partial || (nc > 256) || prior_err);
    chk("frame_done_pulses", done_cnt - done_base, partial ? 0 : 1);
  endtask

  task automatic fill(input int n);
    smp.delete();
    for (int i = 0; i < n; i++) smp.push_back(3'($urandom_range(0, 7)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb;
    logic [31:0] ts;
    ready_mode = 1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_time_stamp", time_stamp, 0);
    chk("rst_time_valid", time_valid, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample_count", sample_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_overflow", overflow, 0);

    smp.delete();
    smp.push_back(3'd5);
    smp.push_back(3'd2);
    run_frame(32'hA5C3_1E07, 38, 0, 1'b0);
    chk("t1_time_stamp", time_stamp, 32'hA5C3_1E07);
    idle(4);

    run_frame(32'hA5C3_1E07, 38, 1, 1'b0);
    chk("t2_time_stamp", time_stamp, 32'hA5C3_1E07);
    idle(4);

    ready_mode = 0;
    smp.delete();
    for (int i = 0; i < 10; i++) smp.push_back(3'(i % 8));
    run_frame($urandom, 62, 2, 1'b0);
    chk("t3_overflow", overflow, 1);
    chk("t3_held", sample_valid, 1);
    ready_mode = 1;
    idle(12);
    chk("t3_drained", sample_valid, 0);

    fill(2);
    run_frame($urandom, 36, 0, 1'b0);
    idle(3);

    ready_mode = 0;
    fill(4);
    start_frame();
    send_bits($urandom, 42, 0);
    chk("t5_queued", sample_valid, 1);
    rst_n = 1'b0;
    frame_active = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_time_stamp", time_stamp, 0);
    chk("t5_time_valid", time_valid, 0);
    chk("t5_sample_valid", sample_valid, 0);
    chk("t5_sample_data", sample_data, 0);
    chk("t5_sample_count", sample_count, 0);
    chk("t5_frame_error", frame_error, 0);
    chk("t5_overflow", overflow, 0);
    ready_mode = 1;
    idle(3);
    chk("t5_empty", sample_valid, 0);

    fill(257);
    run_frame($urandom, 32 + 3 * 257, 0, 1'b0);
    idle(3);

    fill(3);
    start_frame();
    send_bits($urandom, 40, 0);
    fill(2);
    ts = $urandom;
    run_frame(ts, 38, 0, 1'b1);
    chk("t7_time_stamp", time_stamp, ts);
    idle(3);

    for (int f = 0; f < 25; f++) begin
      ready_mode = 2;
      n = $urandom_range(0, 14);
      fill(n);
      nb = 32 + 3 * n;
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(0, nb);
      run_frame($urandom, nb, 2, 1'b0);
      idle($urandom_range(0, 3));
    end

    ready_mode = 1;
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
